// File: rtl/me_stage.sv
// ---------------------------------------------------------------------------
// me_stage -- memory stage of the pipeline.
//
// Retires one instruction at a time from the EX/ME register. ALU results
// pass through with one cycle of latency. Loads and stores run a
// request/acknowledge handshake with the data memory. While that handshake
// is in progress, the stage stalls the upstream pipeline. A watchdog stops
// an access that is never acknowledged.
//
// Parameters
//   DBITS               data / address width
//   REG_INDEX_BIT_WIDTH destination register index width
//   MEM_TIMEOUT         max ACCESS cycles without mem_ack before mem_err
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   in_valid, flush       live instruction in EX/ME, kill its writeback
//   EX_intermediateResult ALU result or memory address
//   EX_regData2           store data
//   EX_rd                 destination register
//   EX_ME_mux_sel         load select
//   EX_wrReg, EX_wrMem    register write enable, memory write (store)
//   mem_req, mem_we       memory request, write enable (registered)
//   mem_addr, mem_wdata   memory address, write data (registered)
//   mem_rdata, mem_ack    memory read data, completion strobe
//   stall                 combinational; upstream EX/ME enable = !stall
//   ME_result, ME_rd      retired result and destination
//   ME_wrReg, ME_valid    register write enable, one-cycle retire pulse
//   mem_err               sticky timeout flag, cleared only by reset
// ---------------------------------------------------------------------------
module me_stage #(
    parameter int DBITS               = 32,
    parameter int REG_INDEX_BIT_WIDTH = 4,
    parameter int MEM_TIMEOUT         = 15
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    input  logic                           flush,
    input  logic [DBITS-1:0]               EX_intermediateResult,
    input  logic [DBITS-1:0]               EX_regData2,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] EX_rd,
    input  logic                           EX_ME_mux_sel,
    input  logic                           EX_wrReg,
    input  logic                           EX_wrMem,
    output logic                           mem_req,
    output logic                           mem_we,
    output logic [DBITS-1:0]               mem_addr,
    output logic [DBITS-1:0]               mem_wdata,
    input  logic [DBITS-1:0]               mem_rdata,
    input  logic                           mem_ack,
    output logic                           stall,
    output logic [DBITS-1:0]               ME_result,
    output logic [REG_INDEX_BIT_WIDTH-1:0] ME_rd,
    output logic                           ME_wrReg,
    output logic                           ME_valid,
    output logic                           mem_err
);

    // Wide enough to hold MEM_TIMEOUT-1 for any legal MEM_TIMEOUT >= 1.
    localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(MEM_TIMEOUT - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // ----------------------------------------------------------------------
    // State registers and their next-state values
    // ----------------------------------------------------------------------
    state_t                         state_reg,     state_next;
    logic [TW-1:0]                  timer_reg,     timer_next;
    logic                           flush_lat_reg, flush_lat_next;
    logic [REG_INDEX_BIT_WIDTH-1:0] lat_rd_reg,    lat_rd_next;
    logic                           lat_wr_reg,    lat_wr_next;
    logic                           lat_store_reg, lat_store_next;

    logic                           mem_req_reg,   mem_req_next;
    logic                           mem_we_reg,    mem_we_next;
    logic [DBITS-1:0]               mem_addr_reg,  mem_addr_next;
    logic [DBITS-1:0]               mem_wdata_reg, mem_wdata_next;
    logic [DBITS-1:0]               result_reg,    result_next;
    logic [REG_INDEX_BIT_WIDTH-1:0] rd_reg,        rd_next;
    logic                           wr_reg_reg,    wr_reg_next;
    logic                           valid_reg,     valid_next;
    logic                           err_reg,       err_next;

    logic                           stall_comb;
    logic                           is_mem_op;
    logic                           kill;

    // A store takes priority over the load select. A flushed instruction is
    // never a memory op, so it cannot start a bus transaction.
    assign is_mem_op = in_valid && !flush && (EX_wrMem || EX_ME_mux_sel);

    // A flush seen in any ACCESS cycle, including the completing one,
    // cancels the writeback.
    assign kill = flush_lat_reg || flush;

    // ----------------------------------------------------------------------
    // Next-state and output logic
    // ----------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        timer_next     = timer_reg;
        flush_lat_next = flush_lat_reg;
        lat_rd_next    = lat_rd_reg;
        lat_wr_next    = lat_wr_reg;
        lat_store_next = lat_store_reg;
        mem_req_next   = mem_req_reg;
        mem_we_next    = mem_we_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        result_next    = result_reg;
        rd_next        = rd_reg;
        wr_reg_next    = wr_reg_reg;
        err_next       = err_reg;
        valid_next     = 1'b0;
        stall_comb     = 1'b0;

        case (state_reg)
            IDLE: begin
                // mem_ack is ignored here. Only a live, unflushed instruction
                // does anything.
                if (is_mem_op) begin
                    stall_comb     = 1'b1;
                    state_next     = ACCESS;
                    timer_next     = '0;
                    flush_lat_next = 1'b0;
                    lat_rd_next    = EX_rd;
                    lat_wr_next    = EX_wrReg;
                    lat_store_next = EX_wrMem;
                    mem_req_next   = 1'b1;
                    mem_we_next    = EX_wrMem;
                    mem_addr_next  = EX_intermediateResult;
                    mem_wdata_next = EX_regData2;
                end else if (in_valid && !flush) begin
                    result_next = EX_intermediateResult;
                    rd_next     = EX_rd;
                    wr_reg_next = EX_wrReg;
                    valid_next  = 1'b1;
                end
            end

            ACCESS: begin
                // EX inputs are ignored. The bus outputs keep their values
                // because nothing below assigns them except on exit.
                flush_lat_next = kill;
                if (mem_ack) begin
                    state_next     = IDLE;
                    mem_req_next   = 1'b0;
                    valid_next     = 1'b1;
                    rd_next        = lat_rd_reg;
                    flush_lat_next = 1'b0;
                    if (!lat_store_reg) begin
                        result_next = mem_rdata;
                    end
                    wr_reg_next = lat_wr_reg && !lat_store_reg && !kill;
                end else if (timer_reg == TIMER_LAST) begin
                    // Give up. The stall is released during this last cycle
                    // so that upstream advances together with the retire
                    // pulse.
                    state_next     = IDLE;
                    mem_req_next   = 1'b0;
                    err_next       = 1'b1;
                    valid_next     = 1'b1;
                    rd_next        = lat_rd_reg;
                    wr_reg_next    = 1'b0;
                    flush_lat_next = 1'b0;
                end else begin
                    stall_comb = 1'b1;
                    timer_next = timer_reg + 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ----------------------------------------------------------------------
    // Registers
    // ----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            timer_reg     <= '0;
            flush_lat_reg <= 1'b0;
            lat_rd_reg    <= '0;
            lat_wr_reg    <= 1'b0;
            lat_store_reg <= 1'b0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            result_reg    <= '0;
            rd_reg        <= '0;
            wr_reg_reg    <= 1'b0;
            valid_reg     <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            timer_reg     <= timer_next;
            flush_lat_reg <= flush_lat_next;
            lat_rd_reg    <= lat_rd_next;
            lat_wr_reg    <= lat_wr_next;
            lat_store_reg <= lat_store_next;
            mem_req_reg   <= mem_req_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            result_reg    <= result_next;
            rd_reg        <= rd_next;
            wr_reg_reg    <= wr_reg_next;
            valid_reg     <= valid_next;
            err_reg       <= err_next;
        end
    end

    // The stall is held low while reset is high, so upstream is not frozen
    // by state that is about to be cleared.
    assign stall     = stall_comb && !reset;

    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign ME_result = result_reg;
    assign ME_rd     = rd_reg;
    assign ME_wrReg  = wr_reg_reg;
    assign ME_valid  = valid_reg;
    assign mem_err   = err_reg;

endmodule

// File: doc/me_stage.md
ME_STAGE -- requirements
Module: me_stage

Interface
REQ-001 Parameter DBITS, default 32, data and address width SHALL be DBITS.
REQ-002 Parameter REG_INDEX_BIT_WIDTH, default 4, destination index width.
REQ-003 Parameter MEM_TIMEOUT, default 15, max ACCESS cycles without ack before error.
REQ-004 clk  in  1  single clock; all state SHALL update on rising edge of clk.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  EX/ME register holds a live instruction.
REQ-007 flush  in  1  kill current/incoming instruction's writeback.
REQ-008 EX_intermediateResult  in  DBITS  ALU result / memory address.
REQ-009 EX_regData2  in  DBITS  store data.
REQ-010 EX_rd  in  REG_INDEX_BIT_WIDTH  destination register.
REQ-011 EX_ME_mux_sel / EX_wrReg / EX_wrMem  in  1 each  load select / reg write / mem write.
REQ-012 mem_req, mem_we  out  1  memory request, write enable (registered).
REQ-013 mem_addr, mem_wdata  out  DBITS  memory address, write data (registered).
REQ-014 mem_rdata  in  DBITS; mem_ack  in  1  read data, completion strobe.
REQ-015 stall  out  1  combinational; upstream EX/ME wrt_en SHALL be driven by !stall.
REQ-016 ME_result  out  DBITS; ME_rd  out  REG_INDEX_BIT_WIDTH; ME_wrReg, ME_valid, mem_err  out  1.

Function
REQ-017 Memory op = in_valid & !flush & (EX_wrMem | EX_ME_mux_sel); EX_wrMem set SHALL mean store regardless of EX_ME_mux_sel.
REQ-018 States: IDLE, ACCESS; no other states.
REQ-019 IDLE, in_valid & !flush & non-memory op: next edge ME_result<=EX_intermediateResult, ME_rd<=EX_rd, ME_wrReg<=EX_wrReg, ME_valid<=1; stall=0 (1-cycle latency).
REQ-020 IDLE, memory op: stall=1 that cycle; next edge -> ACCESS, latch rd/wrReg/load-vs-store, mem_req<=1, mem_we<=EX_wrMem, mem_addr<=EX_intermediateResult, mem_wdata<=EX_regData2, timer<=0.
REQ-021 IDLE, !in_valid or flush: ME_valid<=0, no state change, stall=0.
REQ-022 ACCESS: mem_req/mem_we/mem_addr/mem_wdata SHALL hold stable; inputs from EX ignored; stall=!mem_ack.
REQ-023 ACCESS & mem_ack: next edge -> IDLE, mem_req<=0, ME_valid<=1, ME_rd<=latched rd; load: ME_result<=mem_rdata, ME_wrReg<=latched wrReg; store: ME_result unchanged, ME_wrReg<=0.
REQ-024 ACCESS & !mem_ack: timer increments; when timer==MEM_TIMEOUT-1 and no ack: stall=0 that cycle, next edge -> IDLE, mem_req<=0, mem_err<=1 (sticky), ME_valid<=1, ME_wrReg<=0.
REQ-025 flush asserted any cycle while in ACCESS SHALL be latched; completing op then SHALL write ME_wrReg=0; memory transaction is never aborted.
REQ-026 mem_ack while in IDLE SHALL be ignored.
REQ-027 ME_valid SHALL be a one-cycle pulse per retired instruction; ME_result/ME_rd hold between pulses.
REQ-028 Minimum memory op latency: 2 cycles (accept edge, ack in first ACCESS cycle); back-to-back memory ops SHALL have one IDLE cycle between them.

Reset
REQ-029 reset SHALL force IDLE, timer 0, flush latch 0, and all outputs 0 (mem_req, mem_we, mem_addr, mem_wdata, ME_*, mem_err); stall=0 while reset high.
REQ-030 reset during ACCESS SHALL abandon the transaction: mem_req 0 after that edge, no ME_valid pulse.

Verification
REQ-031 ALU op: in_valid=1, mux_sel=0, wrMem=0, result=0x1234, rd=5, wrReg=1 -> next cycle ME_valid=1, ME_result=0x1234, ME_rd=5, ME_wrReg=1, stall never high.
REQ-032 Load addr 0x40, rd=3, ack 3 cycles after mem_req, rdata=0xDEADBEEF -> stall high 4 cycles, mem_addr=0x40, mem_we=0, then ME_result=0xDEADBEEF, ME_rd=3, ME_wrReg=1 pulse.
REQ-033 Store addr 0x80, data 0xA5A5A5A5, ack first cycle -> mem_we=1, mem_wdata=0xA5A5A5A5, ME_valid pulse with ME_wrReg=0.
REQ-034 Load, no ack for 15 ACCESS cycles -> mem_req drops, mem_err=1 stays until reset, ME_valid pulse with ME_wrReg=0.
REQ-035 Load with flush pulsed mid-ACCESS -> mem_req held until ack, ME_valid pulse with ME_wrReg=0; flush in IDLE with ALU op -> no ME_valid.
REQ-036 reset asserted in ACCESS -> next cycle mem_req=0, state IDLE, no ME_valid; late mem_ack ignored.
